// File: rtl/mcs_bus_bridge.sv
// mcs_bus_bridge: MicroBlaze MCS IO bus to FPro chip-select bridge with
// per-region stall, read latency, timeout abort and a sticky error flag.
module mcs_bus_bridge #(
  parameter logic [31:0] BRG_BASE       = 32'hC000_0000,
  parameter int          NUM_REGIONS    = 2,
  parameter int          RD_LATENCY     = 1,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      io_addr_strobe,
  input  logic                      io_read_strobe,
  input  logic                      io_write_strobe,
  input  logic [3:0]                io_byte_enable,
  input  logic [31:0]               io_address,
  input  logic [31:0]               io_write_data,
  output logic [31:0]               io_read_data,
  output logic                      io_ready,
  output logic [NUM_REGIONS-1:0]    fp_cs,
  output logic                      fp_rd,
  output logic                      fp_wr,
  output logic [19:0]               fp_addr,
  output logic [31:0]               fp_wr_data,
  output logic [3:0]                fp_be,
  input  logic [32*NUM_REGIONS-1:0] fp_rd_data,
  input  logic [NUM_REGIONS-1:0]    fp_wait,
  input  logic                      err_clr,
  output logic                      bus_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [1:0] region;
  logic wr_q, err_q;
  logic [2:0] lat_cnt;
  logic [7:0] wait_cnt;
  logic [31:0] rdata;
  logic [NUM_REGIONS-1:0] cs_mask;
  logic sel_wait;
  logic [31:0] sel_data;
  logic start, valid, done_ok, tmo;
  assign start = state == IDLE && io_addr_strobe;
  assign valid = (io_read_strobe ^ io_write_strobe) && io_address[31:24] == BRG_BASE[31:24]
                 && {1'b0, io_address[23:22]} < 3'(NUM_REGIONS);
  always_comb begin
    cs_mask  = '0;
    sel_wait = 1'b0;
    sel_data = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      cs_mask[r] = region == 2'(r);
      sel_wait   = sel_wait | (cs_mask[r] & fp_wait[r]);
      sel_data   = sel_data | ({32{cs_mask[r]}} & fp_rd_data[32*r +: 32]);
    end
  end
  assign done_ok = state == WAIT && lat_cnt == 3'd0 && !sel_wait;
  assign tmo     = state == WAIT && !done_ok && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // Rejected requests still pass through ACCESS (with every strobe gated off)
  // so error completions share the same two-cycle response slot.
  always_comb begin
    nxt = state == IDLE   ? (io_addr_strobe ? ACCESS : IDLE) :
          state == ACCESS ? (err_q ? DONE : WAIT) :
          state == WAIT   ? (done_ok || tmo ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    io_ready     = state == DONE;
    io_read_data = rdata;
    fp_cs        = (state == ACCESS || state == WAIT) && !err_q ? cs_mask : '0;
    fp_rd        = state == ACCESS && !err_q && !wr_q;
    fp_wr        = state == ACCESS && !err_q && wr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      region     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      lat_cnt    <= '0;
      wait_cnt   <= '0;
      rdata      <= '0;
      fp_addr    <= '0;
      fp_wr_data <= '0;
      fp_be      <= '0;
      bus_err    <= 1'b0;
    end else begin
      if (start) begin
        err_q <= !valid;
        rdata <= '0;
        if (valid) begin
          region     <= io_address[23:22];
          wr_q       <= io_write_strobe;
          fp_addr    <= io_address[21:2];
          fp_wr_data <= io_write_data;
          fp_be      <= io_byte_enable;
        end
      end
      if (state == ACCESS) begin
        lat_cnt  <= wr_q ? 3'd0 : 3'(RD_LATENCY - 1);
        wait_cnt <= '0;
      end
      if (state == WAIT) begin
        lat_cnt  <= lat_cnt == 3'd0 ? 3'd0 : lat_cnt - 3'd1;
        wait_cnt <= wait_cnt + 8'd1;
        if (done_ok) rdata <= wr_q ? 32'h0 : sel_data;
        else if (tmo) rdata <= wr_q ? 32'h0 : 32'hDEAD_BEEF;
      end
      bus_err <= (start && !valid) || tmo ? 1'b1 : err_clr ? 1'b0 : bus_err;
    end
endmodule

// File: doc/mcs_bus_bridge.md
MCS_BUS_BRIDGE -- requirements
Module: mcs_bus_bridge

Interface
REQ-001 SHALL provide parameter BRG_BASE, default 32'hC000_0000, bridge base; io_address[31:24] compared against BRG_BASE[31:24].
REQ-002 SHALL provide parameter NUM_REGIONS, default 2, range 1..4; number of FPro chip-select regions.
REQ-003 SHALL provide parameter RD_LATENCY, default 1, range 1..4; cycles from fp_rd to valid fp_rd_data.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 16, range RD_LATENCY+2..255; abort limit for WAIT.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 io_addr_strobe, io_read_strobe, io_write_strobe  in  1 each  MCS IO bus strobes.
REQ-008 io_byte_enable  in  4  MCS byte enables.
REQ-009 io_address, io_write_data  in  32 each  MCS address and write data.
REQ-010 io_read_data  out  32  read data to MCS; io_ready  out  1  one-cycle completion pulse.
REQ-011 fp_cs  out  NUM_REGIONS  one-hot region select; fp_rd, fp_wr  out  1 each  single-cycle access strobes.
REQ-012 fp_addr  out  20  word address = io_address[21:2]; fp_wr_data  out  32; fp_be  out  4.
REQ-013 fp_rd_data  in  32*NUM_REGIONS  region r data on bits [32r+31:32r].
REQ-014 fp_wait  in  NUM_REGIONS  per-region stall request.
REQ-015 err_clr  in  1  clears bus_err; bus_err  out  1  sticky error flag.

Function
REQ-016 SHALL implement FSM IDLE, ACCESS, WAIT, DONE.
REQ-017 IDLE: on io_addr_strobe with exactly one of read/write strobe, base match and io_address[23:22] < NUM_REGIONS -> register address, data, byte enables, region, direction; go ACCESS.
REQ-018 IDLE: strobe with base miss, region >= NUM_REGIONS, or both/neither read and write strobes -> no FPro access, bus_err set, read data 32'h0000_0000; go DONE.
REQ-019 ACCESS: one cycle; fp_cs[region]=1, fp_rd or fp_wr =1; go WAIT.
REQ-020 fp_cs held through ACCESS and WAIT; fp_addr, fp_wr_data, fp_be registered and stable from ACCESS until return to IDLE.
REQ-021 WAIT read: latency counter expires RD_LATENCY cycles after the fp_rd cycle; at first cycle with counter expired and fp_wait[region]=0, capture fp_rd_data slice; go DONE.
REQ-022 WAIT write: counter 0; leave on first cycle with fp_wait[region]=0; go DONE.
REQ-023 Timeout: WAIT-cycle counter; on reaching TIMEOUT_CYCLES -> abort, io_read_data = 32'hDEAD_BEEF (reads), bus_err set; go DONE.
REQ-024 DONE: io_ready=1 exactly one cycle, io_read_data valid that cycle (0 for writes); go IDLE.
REQ-025 Latency, no stall: strobe sampled cycle T, fp_rd/fp_wr at T+1; read io_ready at T+2+RD_LATENCY; write io_ready at T+3.
REQ-026 Strobes outside IDLE SHALL be ignored; no queueing.
REQ-027 bus_err: set on REQ-018/REQ-023 events, cleared by err_clr; simultaneous set and clear -> set wins.
REQ-028 fp_rd, fp_wr, fp_cs SHALL be 0 in IDLE and DONE.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE; io_ready, io_read_data, fp_cs, fp_rd, fp_wr, fp_addr, fp_wr_data, fp_be, bus_err, all counters = 0.
REQ-030 Reset mid-transaction SHALL abort it without io_ready; first post-reset cycle in IDLE.

Verification
REQ-031 Write 0xC000_0010, data 32'h1234_5678, be 4'hF, RD_LATENCY=1 -> fp_cs=2'b01, fp_wr at T+1, fp_addr=20'h4, io_ready at T+3.
REQ-032 Read 0xC040_0008, fp_rd_data region1 = 32'hA5A5_0001, RD_LATENCY=3 -> fp_cs=2'b10, fp_addr=20'h2, io_read_data=32'hA5A5_0001 with io_ready at T+5.
REQ-033 Read region0 with fp_wait[0] high 4 cycles past latency -> io_ready delayed 4 cycles, correct data, bus_err=0.
REQ-034 fp_wait[0] stuck high, TIMEOUT_CYCLES=16 -> io_ready after 16 WAIT cycles, io_read_data=32'hDEAD_BEEF, bus_err=1; err_clr pulse -> bus_err=0.
REQ-035 Read 0x8000_0000 (base miss) and 0xC080_0000 (region 2, NUM_REGIONS=2) -> no fp_cs, io_ready at T+2, data 0, bus_err=1.
REQ-036 reset_n low during WAIT -> all outputs 0 immediately, no io_ready; next write completes per REQ-031.
